// File: rtl/mem_write_monitor.sv
// Store monitor on the data-memory write port: judges pass/fail/timeout and logs accepted stores.
// Latency: verdict flags change on the edge that samples the deciding store; log head visible one cycle after push.
// Backpressure: none toward the processor; a store arriving at a full log without a pop is dropped and flagged sticky.

// Generic first-word-fall-through FIFO used for the store log.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: wr_rdy drops when full unless the head is popped on the same edge.
module fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty FIFO is meaningless, so it is only honoured with data present.
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign rd_vld  = (count != '0);
    assign do_pop  = rd_vld && rd_rdy;
    assign wr_rdy  = (count != FULL_CNT) || do_pop;
    assign do_push = wr_vld && wr_rdy;

    // Head is forced to zero while empty so stale entries never leak out after reset.
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    // Pointers wrap naturally at the power-of-two depth; occupancy tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; no reset needed because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end
endmodule

module mem_write_monitor #(
    parameter logic [31:0] PASS_ADDR      = 32'd84,
    parameter logic [31:0] PASS_DATA      = 32'd7,
    parameter logic [31:0] SCRATCH_ADDR   = 32'd80,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          LOG_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        log_rd,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] store_count,
    output logic [31:0] cycle_count,
    output logic        log_valid,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic        log_overflow
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    // Last RUN cycle index before the run is declared timed out.
    localparam logic [31:0] LAST_RUN_CYCLE = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic        accept;
    logic        log_push_rdy;
    logic [63:0] log_head;

    // Stores only matter while the run is live; terminal states ignore the bus.
    assign accept = memwrite && (state_q == ST_RUN);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: store checks outrank the timeout, so a scratch store on the
    // last cycle keeps the run alive. The timeout uses >= so that such a run
    // still times out on the following cycle rather than running forever.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (accept && (dataadr == PASS_ADDR) && (writedata == PASS_DATA)) begin
                state_d = ST_PASS;
            end else if (accept && (dataadr != SCRATCH_ADDR)) begin
                state_d = ST_FAIL;
            end else if (!accept && (cycle_count >= LAST_RUN_CYCLE)) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    // Verdict flags come straight off the state register.
    assign pass    = (state_q == ST_PASS);
    assign fail    = (state_q == ST_FAIL);
    assign timeout = (state_q == ST_TIMEOUT);
    assign done    = pass || fail || timeout;

    // Run-cycle counter: counts every edge spent in RUN, including the exit edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if (state_q == ST_RUN) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // Accepted-store counter, saturating so a long run never wraps to a small value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            store_count <= '0;
        end else if (accept && (store_count != 16'hFFFF)) begin
            store_count <= store_count + 16'd1;
        end
    end

    // Sticky overflow: a store that the full log could not take is remembered until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            log_overflow <= 1'b0;
        end else if (accept && !log_push_rdy) begin
            log_overflow <= 1'b1;
        end
    end

    fifo #(
        .WIDTH (64),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk    (clk),
        .rst    (reset),
        .wr_vld (accept),
        .wr_dat ({dataadr, writedata}),
        .wr_rdy (log_push_rdy),
        .rd_vld (log_valid),
        .rd_rdy (log_rd),
        .rd_dat (log_head)
    );

    assign log_addr = log_head[63:32];
    assign log_data = log_head[31:0];
endmodule

// File: tb/tb_mem_write_monitor.sv
// Bench for mem_write_monitor: directed stores checked against a behavioural model every cycle,
// plus hand-computed literal expectations at key points.
// Inputs are driven 1ns after the rising edge; outputs are compared on the falling edge.
module tb_mem_write_monitor;
    localparam int TO  = 20;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        log_rd = 1'b0;
    logic        done, pass, fail, timeout;
    logic [15:0] store_count;
    logic [31:0] cycle_count;
    logic        log_valid;
    logic [31:0] log_addr, log_data;
    logic        log_overflow;

    int n_chk  = 0;
    int n_pass = 0;

    mem_write_monitor #(
        .PASS_ADDR      (32'd84),
        .PASS_DATA      (32'd7),
        .SCRATCH_ADDR   (32'd80),
        .TIMEOUT_CYCLES (TO),
        .LOG_DEPTH      (DEP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .dataadr      (dataadr),
        .writedata    (writedata),
        .log_rd       (log_rd),
        .done         (done),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .store_count  (store_count),
        .cycle_count  (cycle_count),
        .log_valid    (log_valid),
        .log_addr     (log_addr),
        .log_data     (log_data),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: verdict as a small integer, counts as plain ints, log as a queue.
    int          m_state = 0;   // 0 running, 1 passed, 2 failed, 3 timed out
    int          m_cycles = 0;
    int          m_stores = 0;
    bit          m_ovf = 1'b0;
    logic [63:0] m_log[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_cycles = 0; m_stores = 0; m_ovf = 1'b0;
            m_log.delete();
        end else begin
            if (log_rd && m_log.size() > 0) void'(m_log.pop_front());
            if (m_state == 0) begin
                m_cycles++;
                if (memwrite) begin
                    if (m_stores < 65535) m_stores++;
                    if (m_log.size() < DEP) m_log.push_back({dataadr, writedata});
                    else m_ovf = 1'b1;
                    if (dataadr == 84 && writedata == 7) m_state = 1;
                    else if (dataadr != 80) m_state = 2;
                end else if (m_cycles >= TO) begin
                    m_state = 3;
                end
            end
        end
    end

    // Every cycle outside reset, all outputs must agree with the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("done",      {31'd0, done},         {31'd0, m_state != 0});
            chk("pass",      {31'd0, pass},         {31'd0, m_state == 1});
            chk("fail",      {31'd0, fail},         {31'd0, m_state == 2});
            chk("timeout",   {31'd0, timeout},      {31'd0, m_state == 3});
            chk("store_cnt", {16'd0, store_count},  32'(m_stores));
            chk("cycle_cnt", cycle_count,           32'(m_cycles));
            chk("log_valid", {31'd0, log_valid},    {31'd0, m_log.size() > 0});
            chk("log_addr",  log_addr,  m_log.size() > 0 ? m_log[0][63:32] : 32'd0);
            chk("log_data",  log_data,  m_log.size() > 0 ? m_log[0][31:0]  : 32'd0);
            chk("log_ovf",   {31'd0, log_overflow}, {31'd0, m_ovf});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rd);
        memwrite = 1'b1; dataadr = a; writedata = d; log_rd = rd;
        step();
        memwrite = 1'b0; log_rd = 1'b0;
    endtask

    // Pulse reset between edges; the next rising edge is the first monitored edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int n;
        // Reset state
        step();
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_store_cnt", {16'd0, store_count}, 32'd0);
        chk("rst_log_valid", {31'd0, log_valid}, 32'd0);
        reset = 1'b0;

        // Scratch store then pass store -> PASS, log drains in order
        store(32'd80, 32'd3, 1'b0);
        step(); step();
        store(32'd84, 32'd7, 1'b0);
        chk("t1_pass", {31'd0, pass}, 32'd1);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_store_cnt", {16'd0, store_count}, 32'd2);
        chk("t1_cycle_cnt", cycle_count, 32'd4);
        chk("t1_head0_addr", log_addr, 32'd80);
        chk("t1_head0_data", log_data, 32'd3);
        log_rd = 1'b1; step();
        chk("t1_head1_addr", log_addr, 32'd84);
        chk("t1_head1_data", log_data, 32'd7);
        step(); log_rd = 1'b0;
        chk("t1_empty", {31'd0, log_valid}, 32'd0);

        // Wrong data at the pass address -> FAIL; later stores ignored
        pulse_reset();
        store(32'd84, 32'd6, 1'b0);
        chk("t2_fail", {31'd0, fail}, 32'd1);
        chk("t2_store_cnt", {16'd0, store_count}, 32'd1);
        store(32'd84, 32'd7, 1'b0);
        chk("t2_still_fail", {31'd0, fail}, 32'd1);
        chk("t2_no_pass", {31'd0, pass}, 32'd0);
        chk("t2_store_cnt_hold", {16'd0, store_count}, 32'd1);

        // No stores -> TIMEOUT after the 20th edge, counter frozen at 20
        pulse_reset();
        for (int i = 0; i < TO - 1; i++) step();
        chk("t3_not_yet", {31'd0, timeout}, 32'd0);
        chk("t3_cycle_19", cycle_count, 32'd19);
        step();
        chk("t3_timeout", {31'd0, timeout}, 32'd1);
        chk("t3_cycle_20", cycle_count, 32'd20);
        step(); step();
        chk("t3_cycle_frozen", cycle_count, 32'd20);

        // Scratch store on the 20th edge keeps the run alive for that cycle
        pulse_reset();
        for (int i = 0; i < TO - 1; i++) step();
        store(32'd80, 32'd1, 1'b0);
        chk("t3b_no_timeout", {31'd0, timeout}, 32'd0);
        chk("t3b_not_done", {31'd0, done}, 32'd0);
        chk("t3b_cycle_20", cycle_count, 32'd20);
        pulse_reset();

        // Six stores, no pops -> four held, overflow set
        for (int i = 1; i <= 6; i++) store(32'd80, 32'(i), 1'b0);
        chk("t4_ovf", {31'd0, log_overflow}, 32'd1);
        chk("t4_store_cnt", {16'd0, store_count}, 32'd6);
        chk("t4_head_data", log_data, 32'd1);
        n = 0;
        for (int i = 0; i < 8 && log_valid; i++) begin n++; log_rd = 1'b1; step(); end
        log_rd = 1'b0;
        chk("t4_held", 32'(n), 32'd4);

        // Full log: push and pop together -> no overflow, occupancy stays 4
        pulse_reset();
        for (int i = 1; i <= 4; i++) store(32'd80, 32'(i), 1'b0);
        chk("t4b_ovf_before", {31'd0, log_overflow}, 32'd0);
        store(32'd80, 32'd5, 1'b1);
        chk("t4b_ovf_after", {31'd0, log_overflow}, 32'd0);
        chk("t4b_head_data", log_data, 32'd2);
        n = 0;
        for (int i = 0; i < 8 && log_valid; i++) begin n++; log_rd = 1'b1; step(); end
        log_rd = 1'b0;
        chk("t4b_held", 32'(n), 32'd4);
        // Empty log: pop ignored, push lands
        log_rd = 1'b1; step(); log_rd = 1'b0;
        chk("t4b_empty_pop", {31'd0, log_valid}, 32'd0);
        store(32'd80, 32'd9, 1'b1);
        chk("t4b_push_empty_valid", {31'd0, log_valid}, 32'd1);
        chk("t4b_push_empty_data", log_data, 32'd9);

        // Asynchronous reset in PASS clears outputs without an edge
        pulse_reset();
        store(32'd84, 32'd7, 1'b0);
        chk("t5_pass", {31'd0, pass}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_pass", {31'd0, pass}, 32'd0);
        chk("t5_rst_done", {31'd0, done}, 32'd0);
        chk("t5_rst_store_cnt", {16'd0, store_count}, 32'd0);
        chk("t5_rst_cycle_cnt", cycle_count, 32'd0);
        chk("t5_rst_log_valid", {31'd0, log_valid}, 32'd0);
        chk("t5_rst_log_addr", log_addr, 32'd0);
        reset = 1'b0;
        store(32'd84, 32'd7, 1'b0);
        chk("t5_repass", {31'd0, pass}, 32'd1);
        chk("t5_store_cnt", {16'd0, store_count}, 32'd1);
        chk("t5_cycle_cnt", cycle_count, 32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
